// File: rtl/mac_seq_pkg.sv
// Shared types and constants for the MAC operand sequencer.
// Operand widths, FSM states and the Q-preserving hold encoding.
package mac_seq_pkg;

  localparam int OPW  = 4;
  localparam int ACCW = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH
  } state_t;

  typedef struct packed {
    logic [OPW-1:0] a;
    logic [OPW-1:0] b;
  } pair_t;

  localparam logic [OPW-1:0] HOLD_A   = '0;
  localparam logic [OPW-1:0] HOLD_B   = '0;
  localparam logic           HOLD_MAC = 1'b1;

endpackage

// File: rtl/mac_operand_fifo.sv
// Operand-pair FIFO: registered occupancy, no bypass,
// simultaneous push and pop both honoured.
module mac_operand_fifo
  import mac_seq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 2*OPW,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH+1)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mac_operand_sequencer.sv
// Feeds A/B/MAC to the 4x4 MAC stage in frames of FRAME_LEN
// elements and pulses DONE when Q holds the frame sum.
module mac_operand_sequencer
  import mac_seq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int LEN_W = 4,
  localparam int CW   = $clog2(DEPTH+1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [OPW-1:0]   IN_A,
  input  logic [OPW-1:0]   IN_B,
  input  logic             START,
  input  logic [LEN_W-1:0] FRAME_LEN,
  output logic             BUSY,
  output logic [OPW-1:0]   A,
  output logic [OPW-1:0]   B,
  output logic             MAC,
  output logic             DONE,
  output logic [CW-1:0]    COUNT
);

  state_t           state, state_n;
  logic [LEN_W-1:0] rem, rem_n;
  logic             first, first_n;
  logic [OPW-1:0]   a_n, b_n;
  logic             mac_n;
  logic             done_n;

  pair_t            fifo_din;
  pair_t            fifo_dout;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;

  assign fifo_din = '{a: IN_A, b: IN_B};
  assign push     = IN_VALID && IN_READY;
  assign pop      = (state == S_RUN) && !empty;
  assign IN_READY = !full;
  assign BUSY     = (state != S_IDLE);

  mac_operand_fifo #(
    .DEPTH (DEPTH),
    .W     (2*OPW)
  ) u_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .push  (push),
    .pop   (pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .count (COUNT),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    state_n = state;
    rem_n   = rem;
    first_n = first;
    a_n     = HOLD_A;
    b_n     = HOLD_B;
    mac_n   = HOLD_MAC;
    done_n  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (START && FRAME_LEN != '0) begin
          rem_n   = FRAME_LEN;
          first_n = 1'b1;
          state_n = S_RUN;
        end
      end
      S_RUN: begin
        // Empty FIFO is a bubble: hold Q, keep first/rem.
        if (!empty) begin
          a_n     = fifo_dout.a;
          b_n     = fifo_dout.b;
          mac_n   = ~first;
          first_n = 1'b0;
          rem_n   = rem - LEN_W'(1);
          if (rem == LEN_W'(1)) state_n = S_FLUSH;
        end
      end
      S_FLUSH: begin
        done_n  = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= S_IDLE;
      rem   <= '0;
      first <= 1'b0;
      A     <= HOLD_A;
      B     <= HOLD_B;
      MAC   <= HOLD_MAC;
      DONE  <= 1'b0;
    end else begin
      state <= state_n;
      rem   <= rem_n;
      first <= first_n;
      A     <= a_n;
      B     <= b_n;
      MAC   <= mac_n;
      DONE  <= done_n;
    end
  end

endmodule

// File: tb/tb_mac_operand_sequencer.sv
// Randomized and directed bench for mac_operand_sequencer with a
// frame-level reference model and a model of the downstream MAC.
module tb_mac_operand_sequencer;
  import mac_seq_pkg::*;

  localparam int DEPTH = 4;
  localparam int LEN_W = 4;
  localparam int CW    = $clog2(DEPTH+1);

  logic             CLK = 1'b0;
  logic             RST;
  logic             IN_VALID;
  logic             IN_READY;
  logic [OPW-1:0]   IN_A;
  logic [OPW-1:0]   IN_B;
  logic             START;
  logic [LEN_W-1:0] FRAME_LEN;
  logic             BUSY;
  logic [OPW-1:0]   A;
  logic [OPW-1:0]   B;
  logic             MAC;
  logic             DONE;
  logic [CW-1:0]    COUNT;

  mac_operand_sequencer #(
    .DEPTH (DEPTH),
    .LEN_W (LEN_W)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .IN_A      (IN_A),
    .IN_B      (IN_B),
    .START     (START),
    .FRAME_LEN (FRAME_LEN),
    .BUSY      (BUSY),
    .A         (A),
    .B         (B),
    .MAC       (MAC),
    .DONE      (DONE),
    .COUNT     (COUNT)
  );

  always #5 CLK = ~CLK;

  int tests  = 0;
  int failed = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               tag, got, exp, $time);
    end
  endtask

  // Frame-level model: pending pairs, elements still owed,
  // flush/DONE timing, and the arithmetic frame sum.
  int mq_a[$];
  int mq_b[$];
  int need  = 0;
  int idx   = 0;
  int sum   = 0;
  int flush = 0;
  int qd    = 0;
  int done_q    = 0;
  int done_seen = 0;

  task automatic model_clear();
    mq_a.delete();
    mq_b.delete();
    need  = 0;
    idx   = 0;
    sum   = 0;
    flush = 0;
    qd    = 0;
  endtask

  task automatic step();
    int pa, pb, pm, sz, busy_pre, nflush, done_e;
    int ea, eb, emac;
    pa = int'(A);
    pb = int'(B);
    pm = int'(MAC);
    @(posedge CLK);
    qd = pm ? ((qd + pa*pb) % 256) : pa*pb;
    sz = mq_a.size();
    busy_pre = (need > 0 || flush != 0) ? 1 : 0;
    done_e = flush;
    nflush = 0;
    ea = 0;
    eb = 0;
    emac = 1;
    if (need > 0 && sz > 0) begin
      ea = mq_a.pop_front();
      eb = mq_b.pop_front();
      emac = (idx == 0) ? 0 : 1;
      sum += ea*eb;
      idx++;
      need--;
      if (need == 0) nflush = 1;
    end
    flush = nflush;
    if (busy_pre == 0 && START && FRAME_LEN != 0) begin
      need = int'(FRAME_LEN);
      idx  = 0;
      sum  = 0;
    end
    if (IN_VALID && sz < DEPTH) begin
      mq_a.push_back(int'(IN_A));
      mq_b.push_back(int'(IN_B));
    end
    #1;
    chk("A", A, ea);
    chk("B", B, eb);
    chk("MAC", MAC, emac);
    chk("DONE", DONE, done_e);
    chk("BUSY", BUSY, (need > 0 || flush != 0) ? 1 : 0);
    chk("COUNT", COUNT, mq_a.size());
    chk("IN_READY", IN_READY, (mq_a.size() != DEPTH) ? 1 : 0);
    if (done_e != 0) begin
      chk("Q_at_DONE", qd, sum % 256);
      done_q = qd;
      done_seen++;
    end
  endtask

  task automatic drv(input int v, input int a, input int b,
                     input int st, input int len);
    IN_VALID  = v[0];
    IN_A      = a[OPW-1:0];
    IN_B      = b[OPW-1:0];
    START     = st[0];
    FRAME_LEN = len[LEN_W-1:0];
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drv(0, 0, 0, 0, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_A"}, A, 0);
    chk({tag, "_B"}, B, 0);
    chk({tag, "_MAC"}, MAC, 1);
    chk({tag, "_DONE"}, DONE, 0);
    chk({tag, "_BUSY"}, BUSY, 0);
    chk({tag, "_COUNT"}, COUNT, 0);
    chk({tag, "_IN_READY"}, IN_READY, 1);
  endtask

  task automatic do_reset();
    #2;
    RST = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
    model_clear();
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  initial begin
    int dseen;
    RST = 1'b1;
    IN_VALID = 1'b0;
    IN_A = '0;
    IN_B = '0;
    START = 1'b0;
    FRAME_LEN = '0;
    #1;
    check_reset_outputs("rst_init");
    @(negedge CLK);
    RST = 1'b0;
    idle(2);

    // Preload three pairs then a frame of 3.
    drv(1, 2, 3, 0, 0);
    drv(1, 4, 5, 0, 0);
    drv(1, 1, 7, 0, 0);
    drv(0, 0, 0, 1, 3);
    idle(6);
    chk("preload_q", done_q, 33);

    // Frame of 2 with a 3-cycle bubble gap.
    drv(1, 3, 3, 1, 2);
    idle(3);
    drv(1, 2, 2, 0, 0);
    idle(4);
    chk("gap_q", done_q, 13);

    // Fill FIFO past capacity, then pop one element.
    for (int i = 0; i < 5; i++) drv(1, i+1, i+2, 0, 0);
    chk("full_count", COUNT, DEPTH);
    chk("full_ready", IN_READY, 0);
    drv(0, 0, 0, 1, 1);
    idle(3);
    chk("after_pop_count", COUNT, 3);
    chk("after_pop_ready", IN_READY, 1);

    // Reset in the middle of a frame.
    drv(0, 0, 0, 1, 3);
    idle(1);
    do_reset();
    dseen = done_seen;
    idle(5);
    chk("no_done_after_rst", done_seen, dseen);

    // Accumulator wrap.
    drv(1, 15, 15, 0, 0);
    drv(1, 15, 15, 0, 0);
    drv(0, 0, 0, 1, 2);
    idle(5);
    chk("wrap_q", done_q, 194);

    // START while busy, then START in the DONE cycle.
    drv(1, 1, 1, 0, 0);
    drv(1, 2, 2, 1, 2);
    drv(0, 0, 0, 1, 5);
    for (int i = 0; i < 20 && !DONE; i++) idle(1);
    chk("done_wait", DONE, 1);
    chk("busy_frame_q", done_q, 5);
    drv(1, 6, 2, 1, 1);
    idle(4);
    chk("b2b_q", done_q, 12);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      drv(int'($urandom_range(0, 1)), int'($urandom_range(1, 15)),
          int'($urandom_range(1, 15)),
          ($urandom_range(0, 5) == 0) ? 1 : 0,
          int'($urandom_range(0, 5)));
    end
    for (int i = 0; i < 30; i++) drv(1, 3, 5, 0, 0);
    idle(10);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/mac_operand_sequencer.md
Name: mac_operand_sequencer

Overview:
Upstream feeder for the 4x4 multiply-accumulate stage (A, B, MAC in; 8-bit accumulator Q out, asynchronously cleared by RST).
- Buffers incoming operand pairs in a small FIFO.
- Groups the pairs into dot-product frames of programmable length.
- Drives A/B/MAC so the downstream accumulator clears on the first element of each frame and accumulates the rest.
- Pulses DONE in the exact cycle Q holds the final frame sum.

Parameters:
DEPTH, 4, operand FIFO entries; power of 2, minimum 2
LEN_W, 4, width of frame-length field; maximum frame = 2^LEN_W-1 elements

Ports:
CLK  in  1  clock, rising edge
RST  in  1  reset, asynchronous, active-high
IN_VALID  in  1  operand pair offered
IN_READY  out  1  FIFO can accept (= not full)
IN_A  in  4  operand A of offered pair
IN_B  in  4  operand B of offered pair
START  in  1  frame start request, sampled in IDLE only
FRAME_LEN  in  LEN_W  element count, sampled with START
BUSY  out  1  frame in progress (RUN or FLUSH)
A  out  4  multiplicand to MAC stage, registered
B  out  4  multiplier to MAC stage, registered
MAC  out  1  0 = load product, 1 = accumulate; registered
DONE  out  1  one-cycle pulse; downstream Q holds the final frame sum this cycle
COUNT  out  $clog2(DEPTH+1)  FIFO occupancy

Behaviour:
- Reset values (RST high, asynchronous):
  - A=0, B=0, MAC=1, DONE=0, BUSY=0, COUNT=0, IN_READY=1.
  - FIFO is emptied; FSM goes to IDLE.
- Hold encoding: A=0, B=0, MAC=1.
  - Downstream computes Q+0, so Q is held. It is driven whenever no element is issued.
- FIFO:
  - Push when IN_VALID && IN_READY, in any FSM state (preloading in IDLE is allowed).
  - Pop only by the FSM.
  - No bypass: a pair pushed at edge k is poppable from edge k+1.
  - Push and pop in the same cycle are both honoured; COUNT is unchanged.
  - IN_READY = (COUNT != DEPTH), combinational from registered COUNT.
- FSM states: IDLE, RUN, FLUSH.
- IDLE:
  - Outputs hold the hold encoding.
  - On START && FRAME_LEN != 0: latch remaining=FRAME_LEN, set first=1, go to RUN.
  - START with FRAME_LEN == 0 is ignored.
- RUN:
  - If the FIFO is non-empty, each edge pops one pair and registers A=IN_A, B=IN_B, MAC=~first.
  - After an issue: first is cleared and remaining is decremented.
  - If the FIFO is empty (bubble), the hold encoding is registered. first and remaining are unchanged, so a pending first element still loads with MAC=0.
  - When the issue with remaining==1 occurs, go to FLUSH.
- FLUSH (one cycle):
  - Registers the hold encoding and DONE=1, then returns to IDLE.
  - Timing: the last element is on A/B during cycle t; the MAC stage captures the final Q at edge t+1; DONE is high during cycle t+1 only.
- BUSY = (state != IDLE).
  - BUSY is 0 while DONE is high, so a START in that cycle is accepted (back-to-back frames).
- START while BUSY: ignored, with no side effects.
- Latency: from START to the first issue is 1 edge if the FIFO is non-empty. Frame duration = FRAME_LEN + bubbles + 1 cycles.
- Arithmetic: the sequencer performs no arithmetic on operands. The downstream sum wraps mod 256 (max product 225). No saturation or overflow flag.
- Reset mid-frame: frame abandoned, FIFO contents discarded, no DONE. The downstream Q is cleared by the same RST.

Decomposition:
- Package mac_seq_pkg holds:
  - the state enum (IDLE, RUN, FLUSH);
  - OPW=4 (operand width) and ACCW=8 (accumulator width);
  - the hold-encoding constants (HOLD_A=0, HOLD_B=0, HOLD_MAC=1).
- One sub-module, mac_operand_fifo:
  - parameters DEPTH and width 2*OPW;
  - push, pop, data in/out, COUNT, full, empty;
  - asynchronous RST;
  - pointer wrap mod DEPTH.
- FSM, counters and output registers live in the top level.

Test Plan:
- Reset: assert RST mid-run -> immediately A=0, B=0, MAC=1, DONE=0, BUSY=0, COUNT=0, IN_READY=1; no DONE after release.
- Preload (2,3),(4,5),(1,7), then START with FRAME_LEN=3 -> on consecutive cycles A/B = 2/3, 4/5, 1/7 with MAC = 0, 1, 1; DONE one cycle after 1/7; downstream Q=33 during DONE.
- Frame of length 2: push (3,3), 3-cycle gap, then (2,2) -> hold encoding during the gap; Q=9 through the gap, Q=13 when DONE pulses.
- Push 5 pairs back-to-back with no START -> COUNT=4, IN_READY=0; 5th pair not accepted. START with FRAME_LEN=1 -> one pop, IN_READY returns to 1, COUNT=3.
- Wrap: frame of (15,15),(15,15) -> Q=194 (450 mod 256) during DONE.
- START while BUSY ignored; START in the DONE cycle with FRAME_LEN=1 and pair (6,2) -> next issue has MAC=0; Q=12 at the second DONE.
